// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and sequencer state encoding
package bcd_pkg;

   localparam int DIG_W = 4;
   localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;
   localparam logic [DIG_W-1:0] BCD_ADJ = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// rtl/bcd_serial_adder_ctrl_if.sv - host request/result bundle for the serial BCD adder
interface bcd_serial_adder_ctrl_if #(
   parameter int NDIG = 4
);
   logic                  start;
   logic [4*NDIG-1:0]     a;
   logic [4*NDIG-1:0]     b;
   logic                  cin;
   logic                  busy;
   logic                  done;
   logic [4*NDIG-1:0]     sum;
   logic                  cout;
   logic                  err;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, err
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, err
   );
endinterface

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit decimal adder cell
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [DIG_W-1:0] x,
   input  logic [DIG_W-1:0] y,
   input  logic             ci,
   output logic [DIG_W-1:0] s,
   output logic             co
);

   logic [DIG_W:0] raw;
   logic [DIG_W:0] adj;

   // Out-of-range digits take the same +6 path, so they stay deterministic.
   always_comb begin
      raw = {1'b0, x} + {1'b0, y} + {{DIG_W{1'b0}}, ci};
      adj = raw + {1'b0, BCD_ADJ};
      if (raw > {1'b0, BCD_MAX}) begin
         s  = adj[DIG_W-1:0];
         co = 1'b1;
      end else begin
         s  = raw[DIG_W-1:0];
         co = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// rtl/bcd_serial_adder_ctrl.sv - digit-serial NDIG-digit BCD adder sequencer
// Optional input digit checker enabled by BCD_DIGIT_CHECK_EN.
module bcd_serial_adder_ctrl
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   bcd_serial_adder_ctrl_if.slave  bus
);

   localparam int W  = DIG_W * NDIG;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t          state, state_nx;
   logic [IW-1:0]   idx;
   logic [W-1:0]    a_q, b_q, sum_q;
   logic            carry, cout_q;
   logic [DIG_W-1:0] xd, yd, sd;
   logic            cd;
   logic            last;

   assign xd   = a_q[DIG_W*idx +: DIG_W];
   assign yd   = b_q[DIG_W*idx +: DIG_W];
   assign last = (idx == IW'(NDIG-1));

   bcd_digit_add u_cell (
      .x  (xd),
      .y  (yd),
      .ci (carry),
      .s  (sd),
      .co (cd)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = ADD;
         ADD:     if (last)      state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  carry  <= bus.cin;
                  sum_q  <= '0;
                  cout_q <= 1'b0;
                  idx    <= '0;
               end
            end
            ADD: begin
               sum_q[DIG_W*idx +: DIG_W] <= sd;
               carry <= cd;
               if (last) begin
                  cout_q <= cd;
                  idx    <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE:    idx <= '0;
            default: idx <= '0;
         endcase
      end
   end

   assign bus.busy = (state == ADD);
   assign bus.done = (state == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
   logic err_q;

   // Sticky for the whole operation so it is still visible alongside done.
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (state == IDLE && bus.start)
         err_q <= 1'b0;
      else if (state == ADD && (xd > BCD_MAX || yd > BCD_MAX))
         err_q <= 1'b1;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb/tb_bcd_serial_adder_ctrl.sv - directed self-checking bench for bcd_serial_adder_ctrl
module tb_bcd_serial_adder_ctrl;

   localparam int NDIG = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   bcd_serial_adder_ctrl_if #(.NDIG(NDIG)) bus ();

   bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one add; optionally keep start high (with junk operands) the whole time.
   task automatic do_add(
      input  logic [15:0] av,
      input  logic [15:0] bv,
      input  logic        ci,
      input  bit          hold,
      output logic [15:0] s,
      output logic        co,
      output logic        e,
      output int          bcnt,
      output int          lat,
      output bit          got,
      output logic        done_after,
      output logic        busy_after,
      output logic [15:0] s_after
   );
      @(negedge clk);
      bus.a     = av;
      bus.b     = bv;
      bus.cin   = ci;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = hold;
      bus.a     = 16'h9999;
      bus.b     = 16'h9999;
      bus.cin   = 1'b1;
      bcnt = 0; lat = 0; got = 1'b0;
      s = '0; co = 1'b0; e = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (bus.busy) bcnt++;
         if (bus.done) begin
            got = 1'b1;
            lat = i;
            s   = bus.sum;
            co  = bus.cout;
            e   = bus.err;
         end
      end
      @(negedge clk);
      done_after = bus.done;
      busy_after = bus.busy;
      s_after    = bus.sum;
      bus.start  = 1'b0;
   endtask

   logic [15:0] s, s_after;
   logic        co, e, done_after, busy_after;
   int          bcnt, lat;
   bit          got, saw_done;

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_sum",  32'(bus.sum),  32'h0);
      chk("rst_cout", 32'(bus.cout), 32'h0);
      chk("rst_err",  32'(bus.err),  32'h0);
      rst = 1'b0;

      do_add(16'h0123, 16'h0456, 1'b0, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("a0_done",  32'(got),  32'h1);
      chk("a0_lat",   32'(lat),  32'd5);
      chk("a0_busy",  32'(bcnt), 32'd4);
      chk("a0_sum",   32'(s),    32'h0579);
      chk("a0_cout",  32'(co),   32'h0);
      chk("a0_pulse", 32'(done_after), 32'h0);
      chk("a0_hold",  32'(s_after), 32'h0579);

      do_add(16'h9999, 16'h0001, 1'b0, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("wrap_sum",  32'(s),  32'h0000);
      chk("wrap_cout", 32'(co), 32'h1);

      do_add(16'h0008, 16'h0009, 1'b0, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("c1_sum",  32'(s),  32'h0017);
      chk("c1_cout", 32'(co), 32'h0);

      do_add(16'h0000, 16'h0000, 1'b1, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("cin_sum",   32'(s),    32'h0001);
      chk("cin_busy",  32'(bcnt), 32'd4);
      chk("cin_pulse", 32'(done_after), 32'h0);

      do_add(16'h5678, 16'h4321, 1'b1, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("mix_sum",  32'(s),  32'h0000);
      chk("mix_cout", 32'(co), 32'h1);

      do_add(16'h1234, 16'h4321, 1'b0, 1'b1, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("ign_sum",   32'(s),    32'h5555);
      chk("ign_cout",  32'(co),   32'h0);
      chk("ign_lat",   32'(lat),  32'd5);
      chk("ign_idle",  32'(busy_after), 32'h0);
      chk("ign_hold",  32'(s_after), 32'h5555);

      // Reset in the second ADD cycle aborts without a done pulse.
      @(negedge clk);
      bus.a = 16'h0123; bus.b = 16'h0456; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ab_busy_pre", 32'(bus.busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("ab_busy", 32'(bus.busy), 32'h0);
      chk("ab_sum",  32'(bus.sum),  32'h0);
      chk("ab_done", 32'(bus.done), 32'h0);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      chk("ab_nodone", 32'(saw_done), 32'h0);

      do_add(16'h2468, 16'h1357, 1'b0, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("post_done", 32'(got), 32'h1);
      chk("post_sum",  32'(s),   32'h3825);
      chk("post_err",  32'(e),   32'h0);

`ifdef BCD_DIGIT_CHECK_EN
      do_add(16'h00A1, 16'h0001, 1'b0, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("err_set", 32'(e), 32'h1);
      do_add(16'h0011, 16'h0022, 1'b0, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("err_clr", 32'(e), 32'h0);
      chk("err_sum", 32'(s), 32'h0033);
`else
      do_add(16'h00A1, 16'h0001, 1'b0, 1'b0, s, co, e, bcnt, lat, got, done_after, busy_after, s_after);
      chk("err_off", 32'(e), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
